// File: rtl/msp430_mpsoc_pkg.sv
// Shared types and helpers for MPSoC shared-resource arbiters.
// Imported by the Blackbone external-port arbiter and its sub-blocks.
package msp430_mpsoc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } bb_arb_state_t;

  // Width of an index able to address n distinct items (at least 1 bit).
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/msp430_rr_arbiter.sv
// Combinational round-robin picker: first request at or above the
// pointer, wrapping past NODES-1 to 0.
import msp430_mpsoc_pkg::*;

module msp430_rr_arbiter #(
  parameter int NODES = 4,
  parameter int IW    = idx_w(NODES)
) (
  input  logic [NODES-1:0] i_req,
  input  logic [IW-1:0]    i_ptr,
  output logic [NODES-1:0] o_gnt,
  output logic [IW-1:0]    o_idx,
  output logic             o_vld
);

  function automatic int wrap(input int p, input int i);
    return (p + i) % NODES;
  endfunction

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      if (!o_vld && i_req[wrap(int'(i_ptr), i)]) begin
        o_vld = 1'b1;
        o_gnt[wrap(int'(i_ptr), i)] = 1'b1;
        o_idx = IW'(wrap(int'(i_ptr), i));
      end
    end
  end

endmodule

// File: rtl/msp430_bb_ext_arbiter.sv
// Shares one external Blackbone memory port among NODES tiles,
// round-robin, one outstanding access, per-tile completion ack.
import msp430_mpsoc_pkg::*;

module msp430_bb_ext_arbiter #(
  parameter int AW          = 32,
  parameter int DW          = 32,
  parameter int NODES       = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NODES-1:0][AW-1:0] bb_ext_addr_i,
  input  logic [NODES-1:0][DW-1:0] bb_ext_din_i,
  input  logic [NODES-1:0]         bb_ext_en_i,
  input  logic [NODES-1:0]         bb_ext_we_i,
  output logic [NODES-1:0][DW-1:0] bb_ext_dout_o,
  output logic [NODES-1:0]         bb_ext_ack_o,
  output logic [AW-1:0]            mem_addr,
  output logic [DW-1:0]            mem_din,
  output logic                     mem_en,
  output logic                     mem_we,
  input  logic [DW-1:0]            mem_dout,
  output logic                     busy
);

  localparam int IW = idx_w(NODES);
  localparam int CW = idx_w(MEM_LATENCY + 1);

  bb_arb_state_t    r_state;
  bb_arb_state_t    w_next;
  logic [IW-1:0]    r_ptr;
  logic [IW-1:0]    r_idx;
  logic [AW-1:0]    r_addr;
  logic [DW-1:0]    r_din;
  logic             r_we;
  logic [CW-1:0]    r_cnt;
  logic [NODES-1:0] w_gnt;
  logic [IW-1:0]    w_idx;
  logic             w_vld;

  msp430_rr_arbiter #(
    .NODES (NODES),
    .IW    (IW)
  ) u_rr (
    .i_req (bb_ext_en_i),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_vld (w_vld)
  );

  always_comb begin
    w_next       = r_state;
    bb_ext_ack_o = '0;
    mem_en       = 1'b0;
    mem_addr     = r_addr;
    mem_din      = r_din;
    mem_we       = r_we;
    busy         = (r_state != IDLE);
    unique case (r_state)
      IDLE:    if (w_vld) w_next = ISSUE;
      ISSUE: begin
        mem_en = 1'b1;
        w_next = r_we ? DONE : WAIT;
      end
      WAIT:    if (r_cnt == CW'(1)) w_next = DONE;
      DONE: begin
        bb_ext_ack_o[r_idx] = 1'b1;
        w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Request fields are frozen at grant; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_ptr         <= '0;
      r_idx         <= '0;
      r_addr        <= '0;
      r_din         <= '0;
      r_we          <= 1'b0;
      r_cnt         <= '0;
      bb_ext_dout_o <= '0;
    end else begin
      r_state <= w_next;
      unique case (r_state)
        IDLE: if (w_vld) begin
          r_idx  <= w_idx;
          r_addr <= bb_ext_addr_i[w_idx];
          r_din  <= bb_ext_din_i[w_idx];
          r_we   <= bb_ext_we_i[w_idx];
        end
        ISSUE: r_cnt <= CW'(MEM_LATENCY);
        WAIT: begin
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1))
            bb_ext_dout_o[r_idx] <= mem_dout;
        end
        DONE: r_ptr <= (r_idx == IW'(NODES - 1)) ?
                       '0 : r_idx + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_msp430_bb_ext_arbiter.sv
// Scoreboard bench for the Blackbone external-port arbiter.
// Grant order and read data predicted by the bench, checked on output.
module tb_msp430_bb_ext_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int N  = 4;
  localparam int L  = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0] addr_i = '0;
  logic [N-1:0][DW-1:0] din_i  = '0;
  logic [N-1:0]         en_i   = '0;
  logic [N-1:0]         we_i   = '0;
  logic [N-1:0][DW-1:0] dout_o;
  logic [N-1:0]         ack_o;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_din;
  logic                 mem_en;
  logic                 mem_we;
  logic [DW-1:0]        mem_dout;
  logic                 busy;

  msp430_bb_ext_arbiter #(
    .AW (AW), .DW (DW), .NODES (N), .MEM_LATENCY (L)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bb_ext_addr_i (addr_i),
    .bb_ext_din_i  (din_i),
    .bb_ext_en_i   (en_i),
    .bb_ext_we_i   (we_i),
    .bb_ext_dout_o (dout_o),
    .bb_ext_ack_o  (ack_o),
    .mem_addr      (mem_addr),
    .mem_din       (mem_din),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_dout      (mem_dout),
    .busy          (busy)
  );

  function automatic logic [DW-1:0] memf(input logic [AW-1:0] a);
    if (a == 32'h200) return 32'h1234_5678;
    return a ^ 32'h5A5A_0000;
  endfunction

  // Memory stub: read data appears exactly L cycles after mem_en.
  logic [1:0]    m_cnt;
  logic [DW-1:0] m_pend;
  always @(posedge clk) begin
    if (rst) begin
      m_cnt    <= '0;
      m_pend   <= '0;
      mem_dout <= 32'hBAD0_BAD0;
    end else if (mem_en && !mem_we) begin
      m_cnt    <= 2'(L - 1);
      m_pend   <= memf(mem_addr);
      mem_dout <= 32'hBAD0_BAD0;
    end else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1'b1;
      if (m_cnt == 2'd1) mem_dout <= m_pend;
    end
  end

  typedef struct {
    int            tile;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic [DW-1:0] rdata;
  } txn_t;

  txn_t                 iss_q[$];
  txn_t                 ack_q[$];
  logic [N-1:0]         hold = '0;
  logic [N-1:0][DW-1:0] exp_dout = '0;
  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  task automatic req(input int k, input logic we,
                     input logic [AW-1:0] a,
                     input logic [DW-1:0] d);
    addr_i[k] = a;
    din_i[k]  = d;
    we_i[k]   = we;
    en_i[k]   = 1'b1;
  endtask

  task automatic push_exp(input int k, input logic we,
                          input logic [AW-1:0] a,
                          input logic [DW-1:0] d);
    txn_t t;
    t.tile  = k;
    t.we    = we;
    t.addr  = a;
    t.din   = d;
    t.rdata = we ? '0 : memf(a);
    iss_q.push_back(t);
    ack_q.push_back(t);
  endtask

  // Advance one cycle; pop and compare whatever the DUT produced.
  task automatic step();
    txn_t t;
    @(posedge clk);
    #1;
    cyc++;
    if (mem_en === 1'b1) begin
      n_cmp++;
      if (iss_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_mem_en: cyc %0d got 1 want 0", cyc);
      end else begin
        t = iss_q.pop_front();
        if (mem_addr !== t.addr || mem_din !== t.din ||
            mem_we !== t.we) begin
          n_fail++;
          $display("FAIL issue_t%0d: got a=%h d=%h we=%b want a=%h d=%h we=%b",
                   t.tile, mem_addr, mem_din, mem_we,
                   t.addr, t.din, t.we);
        end
      end
    end
    if (ack_o !== '0) begin
      n_cmp++;
      if (ack_q.size() == 0) begin
        n_fail++;
        $display("FAIL spurious_ack: cyc %0d got %b want 0", cyc, ack_o);
      end else begin
        t = ack_q.pop_front();
        if (!t.we) exp_dout[t.tile] = t.rdata;
        if (ack_o !== (4'(1) << t.tile) || dout_o !== exp_dout) begin
          n_fail++;
          $display("FAIL ack_t%0d: got ack=%b dout=%h want ack=%b dout=%h",
                   t.tile, ack_o, dout_o, 4'(1) << t.tile, exp_dout);
        end
      end
    end
    for (int k = 0; k < N; k++)
      if (ack_o[k] === 1'b1 && !hold[k]) en_i[k] = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int c = 0;
    while ((iss_q.size() != 0 || ack_q.size() != 0) && c < max) begin
      step();
      c++;
    end
    n_cmp++;
    if (iss_q.size() != 0 || ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending want 0/0",
               iss_q.size(), ack_q.size());
    end
    step();
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_drain: got busy=%b want 0", busy);
    end
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    en_i = '0;
    step();
    step();
    rst = 1'b0;
    exp_dout = '0;
    ack_q.delete();
    iss_q.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (ack_o !== '0 || mem_en !== 1'b0 || mem_we !== 1'b0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctl: got ack=%b en=%b we=%b busy=%b want 0",
               ack_o, mem_en, mem_we, busy);
    end
    n_cmp++;
    if (mem_addr !== '0 || mem_din !== '0 || dout_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data: got a=%h d=%h dout=%h want 0",
               mem_addr, mem_din, dout_o);
    end
  endtask

  task automatic test_single_write();
    req(2, 1'b1, 32'h100, 32'hDEAD_BEEF);
    push_exp(2, 1'b1, 32'h100, 32'hDEAD_BEEF);
    step();
    n_cmp++;
    if (mem_en !== 1'b1 || mem_we !== 1'b1 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_cycle1: got en=%b we=%b busy=%b want 1 1 1",
               mem_en, mem_we, busy);
    end
    step();
    n_cmp++;
    if (ack_o !== 4'b0100) begin
      n_fail++;
      $display("FAIL wr_cycle2: got ack=%b want 0100", ack_o);
    end
    step();
    n_cmp++;
    if (busy !== 1'b0 || ack_o !== '0) begin
      n_fail++;
      $display("FAIL wr_cycle3: got busy=%b ack=%b want 0 0000",
               busy, ack_o);
    end
  endtask

  task automatic test_wrap();
    req(0, 1'b0, 32'h040, 32'h0);
    req(3, 1'b0, 32'h300, 32'h0);
    push_exp(3, 1'b0, 32'h300, 32'h0);
    push_exp(0, 1'b0, 32'h040, 32'h0);
    wait_idle(40);
  endtask

  task automatic test_single_read();
    req(1, 1'b0, 32'h200, 32'h0);
    push_exp(1, 1'b0, 32'h200, 32'h0);
    for (int s = 1; s <= 2 + L; s++) begin
      step();
      n_cmp++;
      if (s < 2 + L && ack_o !== '0) begin
        n_fail++;
        $display("FAIL rd_early_ack: cyc %0d got %b want 0000", s, ack_o);
      end else if (s == 2 + L &&
                   (ack_o !== 4'b0010 ||
                    dout_o[1] !== 32'h1234_5678)) begin
        n_fail++;
        $display("FAIL rd_ack: got ack=%b d=%h want 0010 12345678",
                 ack_o, dout_o[1]);
      end
    end
    wait_idle(10);
  endtask

  task automatic test_contention();
    do_reset();
    req(0, 1'b1, 32'h010, 32'hA000_0000);
    req(1, 1'b0, 32'h011, 32'h0);
    req(2, 1'b1, 32'h012, 32'hA000_0002);
    req(3, 1'b0, 32'h013, 32'h0);
    for (int k = 0; k < N; k++)
      push_exp(k, we_i[k], addr_i[k], din_i[k]);
    wait_idle(60);
    req(3, 1'b1, 32'h023, 32'hB000_0003);
    req(0, 1'b0, 32'h020, 32'h0);
    push_exp(0, 1'b0, 32'h020, 32'h0);
    push_exp(3, 1'b1, 32'h023, 32'hB000_0003);
    wait_idle(40);
  endtask

  task automatic test_back_to_back();
    int c = 0;
    hold[1] = 1'b1;
    req(1, 1'b1, 32'h500, 32'hCAFE_0001);
    push_exp(1, 1'b1, 32'h500, 32'hCAFE_0001);
    push_exp(1, 1'b1, 32'h500, 32'hCAFE_0001);
    while (ack_q.size() == 2 && c < 20) begin
      step();
      c++;
    end
    hold[1] = 1'b0;
    wait_idle(40);
  endtask

  task automatic test_reset_mid_read();
    req(2, 1'b1, 32'h600, 32'h0BAD_F00D);
    push_exp(2, 1'b1, 32'h600, 32'h0BAD_F00D);
    wait_idle(20);
    req(1, 1'b0, 32'h210, 32'h0);
    push_exp(1, 1'b0, 32'h210, 32'h0);
    step();
    step();
    rst  = 1'b1;
    en_i = '0;
    step();
    rst = 1'b0;
    ack_q.delete();
    exp_dout = '0;
    n_cmp++;
    if (busy !== 1'b0 || ack_o !== '0 || mem_en !== 1'b0 ||
        dout_o !== '0) begin
      n_fail++;
      $display("FAIL mid_rst: got busy=%b ack=%b en=%b dout=%h want 0",
               busy, ack_o, mem_en, dout_o);
    end
    req(3, 1'b0, 32'h330, 32'h0);
    req(0, 1'b0, 32'h030, 32'h0);
    push_exp(0, 1'b0, 32'h030, 32'h0);
    push_exp(3, 1'b0, 32'h330, 32'h0);
    wait_idle(40);
  endtask

  task automatic test_early_drop();
    int acks = 0;
    req(0, 1'b0, 32'h044, 32'h0);
    push_exp(0, 1'b0, 32'h044, 32'h0);
    step();
    en_i[0] = 1'b0;
    for (int s = 0; s < 10; s++) begin
      step();
      if (ack_o[0] === 1'b1) acks++;
    end
    n_cmp++;
    if (acks != 1 || iss_q.size() != 0 || ack_q.size() != 0) begin
      n_fail++;
      $display("FAIL early_drop: got acks=%0d pend=%0d want 1 0",
               acks, iss_q.size() + ack_q.size());
    end
  endtask

  task automatic test_idle();
    for (int s = 0; s < 6; s++) begin
      step();
      n_cmp++;
      if (busy !== 1'b0 || ack_o !== '0 || mem_en !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_bus: got busy=%b ack=%b en=%b want 0",
                 busy, ack_o, mem_en);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_wrap();
    test_single_read();
    test_contention();
    test_back_to_back();
    test_reset_mid_read();
    test_early_drop();
    test_idle();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
